key_debounce_multi: RTL and testbench

//  Parametrised N-channel key debouncer: successor to single-key filter; sits between raw board keys and control FSMs.
//  Per channel: 2-FF synchroniser, stability counter, debounced level, 1-cycle press and release strobes.

---
 rtl/key_debounce_multi_if.sv | 33 +++
 rtl/key_debounce_multi.sv | 190 +++++++++++++++++++
 tb/tb_key_debounce_multi.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if
//   Bundles the key pins and the debounced key events of key_debounce_multi.
//   master : the side that owns the raw pins and consumes events (board / bench)
//   slave  : the debouncer itself
// Signals (all NUM_KEYS wide unless noted):
//   key_in       raw asynchronous key pins
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle strobe, accepted released->pressed
//   key_release  1-cycle strobe, accepted pressed->released
//   key_long     1-cycle strobe, hold time reached
//   key_repeat   1-cycle strobe, auto-repeat tick while held
//   any_pressed  (1 bit) registered OR of key_level
interface key_debounce_multi_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;
  logic                any_pressed;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_long, key_repeat, any_pressed
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_long, key_repeat, any_pressed
  );
endinterface

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   N-channel key debouncer. Each channel has a 2-FF synchroniser, a stability
//   counter, a debounced level and one-cycle press/release strobes. Channels
//   share nothing except the clock and reset.
//
//   Optional feature, macro KEY_REPEAT_EN: per-channel long-press and
//   auto-repeat strobes. Without the macro key_long/key_repeat are tied low.
//
// Ports:
//   clk   in   system clock, all logic on posedge
//   rst   in   asynchronous reset, active high
//   bus   slave modport of key_debounce_multi_if (key_in in, events out)
//
// Parameters:
//   NUM_KEYS      number of independent key channels (>=1)
//   DEBOUNCE_CYC  consecutive stable synchronised cycles to accept a change (>=2)
//   ACTIVE_LOW    1: pin reads 0 when pressed, 0: pin reads 1 when pressed
//   HOLD_CYC      cycles from key_press to key_long (>=2)
//   REPEAT_CYC    cycles between key_repeat strobes after key_long (>=2)

// ---------------------------------------------------------------------------
// One key channel.
//   clk/rst  clock, async active-high reset
//   key_in   raw pin
//   level    debounced level (1 = pressed)
//   press    strobe on accepted press
//   rel      strobe on accepted release
//   lng      long-press strobe (KEY_REPEAT_EN)
//   rpt      auto-repeat strobe (KEY_REPEAT_EN)
// ---------------------------------------------------------------------------
module key_debounce_lane #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int HOLD_CYC     = 50000,
  parameter int REPEAT_CYC   = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic level,
  output logic press,
  output logic rel,
  output logic lng,
  output logic rpt
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  // Pin level of a released key; the synchroniser resets to it so that a
  // reset never looks like a press.
  localparam logic IDLE = ACTIVE_LOW;

  if (DEBOUNCE_CYC < 2 || HOLD_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_param
    $error("key_debounce_lane: DEBOUNCE_CYC, HOLD_CYC and REPEAT_CYC must be >= 2");
  end

  logic          s0, s1;
  logic          p;        // synchronised pin, 1 = pressed
  logic [CW-1:0] cnt;
  logic          accept;   // this edge commits p into level

  assign p      = s1 ^ ACTIVE_LOW;
  assign accept = (p != level) && (cnt == CW'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0    <= IDLE;
      s1    <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s0    <= key_in;
      s1    <= s0;
      press <= 1'b0;
      rel   <= 1'b0;
      if (p == level) begin
        // Any return to the current level restarts the stability window.
        cnt <= '0;
      end else if (accept) begin
        level <= p;
        cnt   <= '0;
        press <= p;
        rel   <= ~p;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX + 1);

  logic [HW-1:0] hcnt;
  logic          rep;        // 0: waiting for long press, 1: repeating
  logic          hold_live;  // key is held and not being released this edge
  logic [HW-1:0] hlim;

  // The release edge itself must not emit long/repeat, so the pending
  // release (accept with p=0) already counts as "not held".
  assign hold_live = level && !(accept && !p);
  assign hlim      = rep ? HW'(REPEAT_CYC - 1) : HW'(HOLD_CYC - 1);

  // hcnt is held at 0 while level==0, which includes the press edge, so it
  // reads j at edge press+j and hits HOLD_CYC-1 one edge before the long
  // strobe is registered. It wraps at every strobe and never exceeds hlim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      rep  <= 1'b0;
      lng  <= 1'b0;
      rpt  <= 1'b0;
    end else begin
      lng <= 1'b0;
      rpt <= 1'b0;
      if (!hold_live) begin
        hcnt <= '0;
        rep  <= 1'b0;
      end else if (hcnt == hlim) begin
        hcnt <= '0;
        rep  <= 1'b1;
        lng  <= ~rep;
        rpt  <= rep;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end
`else
  assign lng = 1'b0;
  assign rpt = 1'b0;
`endif
endmodule

// ---------------------------------------------------------------------------
// Top: array of independent lanes plus the registered any_pressed.
// ---------------------------------------------------------------------------
module key_debounce_multi #(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CYC = 1000,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int HOLD_CYC     = 50000,
  parameter int REPEAT_CYC   = 10000
) (
  input logic                 clk,
  input logic                 rst,
  key_debounce_multi_if.slave bus
);
  if (NUM_KEYS < 1) begin : g_bad_num_keys
    $error("key_debounce_multi: NUM_KEYS must be >= 1");
  end

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;
  logic [NUM_KEYS-1:0] lng;
  logic [NUM_KEYS-1:0] rpt;
  logic                any_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .key_in (bus.key_in[i]),
      .level  (level[i]),
      .press  (press[i]),
      .rel    (rel[i]),
      .lng    (lng[i]),
      .rpt    (rpt[i])
    );
  end

  // Registered so any_pressed trails key_level by exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_q <= 1'b0;
    else     any_q <= |level;
  end

  assign bus.key_level   = level;
  assign bus.key_press   = press;
  assign bus.key_release = rel;
  assign bus.key_long    = lng;
  assign bus.key_repeat  = rpt;
  assign bus.any_pressed = any_q;
endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi (NUM_KEYS=4, DEBOUNCE_CYC=8, ACTIVE_LOW=1,
// HOLD_CYC=40, REPEAT_CYC=16). A timestamp-based model predicts every output
// each cycle; directed sequences pin exact strobe cycles with literals, then
// a long random phase with bouncing keys and occasional resets follows.
module tb_key_debounce_multi;
  localparam int NK = 4;
  localparam int D  = 8;
  localparam int H  = 40;
  localparam int R  = 16;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  key_debounce_multi_if #(.NUM_KEYS(NK)) bus ();

  key_debounce_multi #(
    .NUM_KEYS(NK), .DEBOUNCE_CYC(D), .ACTIVE_LOW(1'b1),
    .HOLD_CYC(H), .REPEAT_CYC(R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A change is accepted at the D-th consecutive edge on which the
  // synchronised value (pin as sampled two edges earlier) differs from the
  // current level. Long/repeat depend only on edges elapsed since the press.
  logic [NK-1:0] kd1, kd2;
  logic [NK-1:0] m_lvl, m_press, m_rel, m_long, m_rep;
  logic          m_any;
  int            run_start [NK];
  int            press_edge [NK];
  int            edge_no;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      kd1 = '1; kd2 = '1;
      m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0; m_any = 1'b0;
      edge_no = 0;
      for (int i = 0; i < NK; i++) begin run_start[i] = -1; press_edge[i] = 0; end
    end else begin
      edge_no++;
      m_any = |m_lvl;
      for (int i = 0; i < NK; i++) begin
        logic p;
        int   el;
        p = ~kd2[i];
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0; m_rep[i] = 1'b0;
        if (p != m_lvl[i]) begin
          if (run_start[i] < 0) run_start[i] = edge_no;
          if (edge_no - run_start[i] + 1 == D) begin
            m_lvl[i] = p; m_press[i] = p; m_rel[i] = ~p; run_start[i] = -1;
            if (p) press_edge[i] = edge_no;
          end
        end else begin
          run_start[i] = -1;
        end
        if (REP_EN && m_lvl[i]) begin
          el = edge_no - press_edge[i];
          if (el == H) m_long[i] = 1'b1;
          else if (el > H && (el - H) % R == 0) m_rep[i] = 1'b1;
        end
      end
      kd2 = kd1;
      kd1 = bus.key_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("key_level",   bus.key_level,   m_lvl);
      chk("key_press",   bus.key_press,   m_press);
      chk("key_release", bus.key_release, m_rel);
      chk("key_long",    bus.key_long,    m_long);
      chk("key_repeat",  bus.key_repeat,  m_rep);
      chk("any_pressed", bus.any_pressed, m_any);
    end
  end

  // Inputs change 1 time unit after the falling edge, well away from posedge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem [NK];
    int rst_left;

    // 1: reset, then idle pins -> everything stays 0
    bus.key_in = 4'hF;
    rst = 1'b1;
    tick(); tick(); tick();
    chk("reset_outputs", {bus.key_level, bus.key_press, bus.key_release,
                          bus.key_long, bus.key_repeat, bus.any_pressed}, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (j % 25 == 24)
        chk("idle_outputs", {bus.key_level, bus.key_press, bus.key_release,
                             bus.key_long, bus.key_repeat, bus.any_pressed}, 32'd0);
    end

    // 2 + 5: clean press of key 0, held, then released
    bus.key_in[0] = 1'b0;
    for (int j = 1; j <= 115; j++) begin
      tick();
      if (j == 9)  chk("press0_early", bus.key_press, 4'b0000);
      if (j == 10) begin
        chk("press0_edge", bus.key_press, 4'b0001);
        chk("level0_edge", bus.key_level, 4'b0001);
        chk("any_lag",     bus.any_pressed, 1'b0);
      end
      if (j == 11) begin
        chk("any_set",     bus.any_pressed, 1'b1);
        chk("press0_once", bus.key_press, 4'b0000);
      end
      if (j == 49 || j == 50 || j == 51)
        chk("long0", bus.key_long[0], REP_EN && j == 50);
      if (j == 65 || j == 66 || j == 82 || j == 98 || j == 114)
        chk("repeat0", bus.key_repeat[0], REP_EN && j != 65);
    end
    bus.key_in[0] = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      tick();
      if (j == 10) chk("release0", bus.key_release, 4'b0001);
      if (j == 11) chk("level0_clr", bus.key_level[0], 1'b0);
      chk("no_strobe_after_rel", {bus.key_long[0], bus.key_repeat[0]}, 2'b00);
    end

    // 3: bouncing press and release on key 1
    for (int s = 0; s < 12; s++) begin
      bus.key_in[1] = s[0];
      for (int c = 0; c < 5; c++) begin
        tick();
        chk("bounce_press", bus.key_press[1], 1'b0);
      end
    end
    bus.key_in[1] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 9 || j == 10) chk("press1", bus.key_press, (j == 10) ? 4'b0010 : 4'b0000);
    end
    for (int s = 0; s < 12; s++) begin
      bus.key_in[1] = ~s[0];
      for (int c = 0; c < 5; c++) begin
        tick();
        chk("bounce_release", bus.key_release[1], 1'b0);
      end
    end
    bus.key_in[1] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 10) chk("release1", bus.key_release, 4'b0010);
    end

    // 4: keys 2 and 3 together
    bus.key_in[3:2] = 2'b00;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 10) chk("press23", bus.key_press, 4'b1100);
    end
    bus.key_in[3:2] = 2'b11;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 10) chk("release23", bus.key_release, 4'b1100);
    end

    // 6: reset while key 0 held and key 1 mid-count
    bus.key_in[0] = 1'b0;
    for (int j = 0; j < 12; j++) tick();
    chk("pre_rst_level0", bus.key_level[0], 1'b1);
    bus.key_in[1] = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    rst = 1'b1;
    #1;
    chk("rst_async", {bus.key_level, bus.key_press, bus.any_pressed}, 32'd0);
    tick(); tick(); tick();
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("no_release_after_rst", bus.key_release, 4'b0000);
      if (j == 9)  chk("repress_early", bus.key_press, 4'b0000);
      if (j == 10) chk("repress", bus.key_press, 4'b0011);
    end
    bus.key_in = 4'hF;
    for (int j = 0; j < 15; j++) tick();

    // Random phase: bouncy segments mixed with long holds, rare resets
    for (int i = 0; i < NK; i++) rem[i] = $urandom_range(1, 30);
    rst_left = 0;
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < NK; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          bus.key_in[i] = ~bus.key_in[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 220))
                                                : int'($urandom_range(1, 12));
        end
      end
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        rst_left = 3;
      end
      tick();
    end
    rst = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
